// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_bcd request side,
//   out_valid/out_ready/out_bin/out_err result side. Define BCD2BIN_ERR_CHECK_EN
//   to flag digits > 9 on out_err; otherwise out_err is tied low.
module bcd_to_binary #(
  parameter int DIGITS = 4,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bcd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bin,
  output logic         out_err
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2*W-1:0] cat;
  logic [W-1:0]   sh_bcd;
  logic [W-1:0]   sh_bin;
  logic [W-1:0]   adj_bcd;

  // One reverse double-dabble step: shift right, then pull every digit
  // that landed at >= 8 back down by 3.
  always_comb begin
    cat     = {bcd_q, bin_q} >> 1;
    sh_bcd  = cat[2*W-1:W];
    sh_bin  = cat[W-1:0];
    adj_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i+:4] >= 4'd8)
        adj_bcd[4*i+:4] = sh_bcd[4*i+:4] - 4'd3;
    end
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd[4*i+:4] > 4'd9)
        bad_digit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
`ifdef BCD2BIN_ERR_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d   = in_bcd;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BCD2BIN_ERR_CHECK_EN
          err_d   = 1'b0;
          if (bad_digit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        bcd_d = adj_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1))
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
`ifdef BCD2BIN_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bin   = bin_q;
`ifdef BCD2BIN_ERR_CHECK_EN
  assign out_err   = err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary (DIGITS=4): latency, values, backpressure,
// mid-conversion reset, back-to-back requests, optional illegal-digit check.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bin;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input string tag,
                         input logic [15:0] bcd,
                         input logic [15:0] exp);
    int n;
    in_valid = 1'b1;
    in_bcd   = bcd;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_bin"}, out_bin, exp);
    chk({tag, "_err"}, out_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int n;
    int acc_cyc[$];
    logic [15:0] res[$];

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 16'h1234;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_bin", out_bin, 0);
    chk("rst_err", out_err, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    convert("c1234", 16'h1234, 16'h04D2);
    convert("c9999", 16'h9999, 16'h270F);
    convert("c0000", 16'h0000, 16'h0000);
    convert("c0001", 16'h0001, 16'h0001);
    convert("c5000", 16'h5000, 16'h1388);

    // Backpressure on 0x0042
    in_valid = 1'b1;
    in_bcd   = 16'h0042;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_lat", n, 16);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_bcd   = 16'h1111;
      tick();
      chk("bp_bin", out_bin, 16'h002A);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", in_ready, 1);
    chk("bp_novalid", out_valid, 0);

    // Reset on the 8th SHIFT edge of 0x5678
    in_valid = 1'b1;
    in_bcd   = 16'h5678;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mr_busy", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_ready", in_ready, 1);
    chk("mr_valid", out_valid, 0);
    chk("mr_bin", out_bin, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mr_noresult", n, 0);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 16'h0001;
    for (int cyc = 0; cyc < 60; cyc++) begin
      logic acc;
      acc = in_valid && in_ready;
      if (out_valid) res.push_back(out_bin);
      tick();
      if (acc) begin
        acc_cyc.push_back(cyc);
        if (acc_cyc.size() == 1) in_bcd = 16'h0002;
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_nacc", acc_cyc.size(), 2);
    chk("b2b_nres", res.size(), 2);
    if (acc_cyc.size() == 2)
      chk("b2b_space", acc_cyc[1] - acc_cyc[0], 18);
    if (res.size() >= 2) begin
      chk("b2b_res0", res[0], 16'h0001);
      chk("b2b_res1", res[1], 16'h0002);
    end

`ifdef BCD2BIN_ERR_CHECK_EN
    tick();
    in_valid = 1'b1;
    in_bcd   = 16'h12A4;
    tick();
    in_valid = 1'b0;
    chk("err_valid", out_valid, 1);
    chk("err_flag", out_err, 1);
    chk("err_bin", out_bin, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("err_idle", in_ready, 1);
    convert("c0010", 16'h0010, 16'h000A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
